// File: rtl/ad56x3_frame_rx.sv
// ad56x3_frame_rx: AD56x3 three-wire slave that deserializes 24-bit frames into Avalon-ST channel A/B samples
module ad56x3_frame_rx #(
    parameter string SIGN_A     = "UNSIGNED",
    parameter string SIGN_B     = "SIGNED",
    parameter int    DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dacSync,
    input  logic                  dacSclk,
    input  logic                  dacDin,
    output logic                  asoValid0,
    output logic [DATA_WIDTH-1:0] asoData0,
    output logic                  asoValid1,
    output logic [DATA_WIDTH-1:0] asoData1,
    output logic                  frmValid,
    output logic [23:0]           frmWord,
    output logic [7:0]            abortCnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_HIGH} state_t;

    localparam logic INV_A = (SIGN_A == "SIGNED");
    localparam logic INV_B = (SIGN_B == "SIGNED");
    localparam logic [DATA_WIDTH-1:0] MSB = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic sync_s1_q, sync_s2_q, sync_d_q;
    logic sclk_s1_q, sclk_s2_q, sclk_d_q;
    logic din_s1_q, din_s2_q;
    logic [1:0] settle_q;
    state_t state_q, state_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [22:0] shreg_q, shreg_d;
    logic [7:0] abort_q, abort_d;
    logic done_q, done_d;
    logic [23:0] word_q, word_d;
    logic sclk_fall, sync_rise;
    logic [2:0] cmd, addr;
    logic wr, sel_a, sel_b;
    logic [DATA_WIDTH-1:0] smp, smp_a, smp_b;

    assign sclk_fall = ~sclk_s2_q & sclk_d_q;
    assign sync_rise = sync_s2_q & ~sync_d_q;
    assign abortCnt  = abort_q;
    assign cmd       = word_q[21:19];
    assign addr      = word_q[18:16];
    assign wr        = (cmd == 3'b000) || (cmd == 3'b010) || (cmd == 3'b011);
    assign sel_a     = wr && ((addr == 3'b000) || (addr == 3'b111));
    assign sel_b     = wr && ((addr == 3'b001) || (addr == 3'b111));
    assign smp       = word_q[15 -: DATA_WIDTH];
    assign smp_a     = INV_A ? smp ^ MSB : smp;
    assign smp_b     = INV_B ? smp ^ MSB : smp;

    // Synchronize the serial inputs and keep one extra stage of sync/sclk for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            {sync_s1_q, sync_s2_q, sync_d_q} <= 3'b111;
            {sclk_s1_q, sclk_s2_q, sclk_d_q} <= 3'b111;
            {din_s1_q, din_s2_q}             <= 2'b00;
        end else begin
            {sync_s1_q, sync_s2_q, sync_d_q} <= {dacSync, sync_s1_q, sync_s2_q};
            {sclk_s1_q, sclk_s2_q, sclk_d_q} <= {dacSclk, sclk_s1_q, sclk_s2_q};
            {din_s1_q, din_s2_q}             <= {dacDin, din_s1_q};
        end
    end

    // Blocks WAIT_HIGH exit until the synchronizers show the real sync level after reset
    always_ff @(posedge clk) begin
        if (reset) settle_q <= 2'd2;
        else       settle_q <= (settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0;
    end

    // Frame FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_HIGH;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            abort_q   <= '0;
            done_q    <= 1'b0;
            word_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            abort_q   <= abort_d;
            done_q    <= done_d;
            word_q    <= word_d;
        end
    end

    // Next-state logic: a 24th falling edge wins over a simultaneous sync rise
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        abort_d   = abort_q;
        done_d    = 1'b0;
        word_d    = word_q;
        case (state_q)
            IDLE: begin
                if (!sync_s2_q) begin
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_fall) begin
                    shreg_d   = {shreg_q[21:0], din_s2_q};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (sclk_fall && bit_cnt_q == 5'd23) begin
                    word_d  = {shreg_q, din_s2_q};
                    done_d  = 1'b1;
                    state_d = WAIT_HIGH;
                end else if (sync_rise) begin
                    state_d = IDLE;
                    abort_d = (bit_cnt_d != 5'd0 && abort_q != 8'hFF) ? abort_q + 8'd1 : abort_q;
                end
            end
            WAIT_HIGH: state_d = (sync_s2_q && settle_q == 2'd0) ? IDLE : WAIT_HIGH;
            default:   state_d = WAIT_HIGH;
        endcase
    end

    // Registered output strobes; sample data holds between strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            asoValid0 <= 1'b0;
            asoValid1 <= 1'b0;
            asoData0  <= '0;
            asoData1  <= '0;
            frmValid  <= 1'b0;
            frmWord   <= '0;
        end else begin
            asoValid0 <= done_q && sel_a;
            asoValid1 <= done_q && sel_b;
            frmValid  <= done_q;
            if (done_q && sel_a) asoData0 <= smp_a;
            if (done_q && sel_b) asoData1 <= smp_b;
            if (done_q) frmWord <= word_q;
        end
    end
endmodule

// File: tb/tb_ad56x3_frame_rx.sv
// tb_ad56x3_frame_rx: scoreboard bench driving AD56x3 serial frames into ad56x3_frame_rx
module tb_ad56x3_frame_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dacSync = 1'b1;
    logic dacSclk = 1'b1;
    logic dacDin = 1'b0;
    logic asoValid0, asoValid1, frmValid;
    logic [13:0] asoData0, asoData1;
    logic [23:0] frmWord;
    logic [7:0] abortCnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_v0 = 0;
    int n_v1 = 0;
    int n_f = 0;
    longint t_v0 = 0;
    longint t_v1 = 0;
    logic [13:0] exp_a[$];
    logic [13:0] exp_b[$];
    logic [23:0] exp_f[$];

    ad56x3_frame_rx dut (
        .clk(clk), .reset(reset), .dacSync(dacSync), .dacSclk(dacSclk), .dacDin(dacDin),
        .asoValid0(asoValid0), .asoData0(asoData0), .asoValid1(asoValid1), .asoData1(asoData1),
        .frmValid(frmValid), .frmWord(frmWord), .abortCnt(abortCnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model(input logic [23:0] w);
        logic [2:0] c, a;
        logic wr;
        c = w[21:19];
        a = w[18:16];
        wr = (c == 3'd0) || (c == 3'd2) || (c == 3'd3);
        exp_f.push_back(w);
        if (wr && (a == 3'd0 || a == 3'd7)) exp_a.push_back(w[15:2]);
        if (wr && (a == 3'd1 || a == 3'd7)) exp_b.push_back(w[15:2] ^ 14'h2000);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            dacSclk = 1'b1;
            dacDin = w[i];
            clks(2);
            dacSclk = 1'b0;
            clks(2);
        end
    endtask

    task automatic end_frame();
        dacSclk = 1'b1;
        clks(2);
        dacSync = 1'b1;
        clks(5);
    endtask

    task automatic frame(input logic [31:0] w, input int n);
        model(w[n-1 -: 24]);
        dacSync = 1'b0;
        clks(2);
        send_bits(w, n);
        end_frame();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (asoValid0) begin
                n_v0++;
                t_v0 = $time;
                check_eq("a_pending", 32'(exp_a.size() > 0), 1);
                if (exp_a.size() > 0) check_eq("a_data", 32'(asoData0), 32'(exp_a.pop_front()));
            end
            if (asoValid1) begin
                n_v1++;
                t_v1 = $time;
                check_eq("b_pending", 32'(exp_b.size() > 0), 1);
                if (exp_b.size() > 0) check_eq("b_data", 32'(asoData1), 32'(exp_b.pop_front()));
            end
            if (frmValid) begin
                n_f++;
                check_eq("f_pending", 32'(exp_f.size() > 0), 1);
                if (exp_f.size() > 0) check_eq("f_word", 32'(frmWord), 32'(exp_f.pop_front()));
            end
        end
    end

    initial begin
        int v0, v1, f;
        logic [13:0] a, b;
        clks(4);
        check_eq("rst_v0", 32'(asoValid0), 0);
        check_eq("rst_v1", 32'(asoValid1), 0);
        check_eq("rst_d0", 32'(asoData0), 0);
        check_eq("rst_d1", 32'(asoData1), 0);
        check_eq("rst_fv", 32'(frmValid), 0);
        check_eq("rst_fw", 32'(frmWord), 0);
        check_eq("rst_abort", 32'(abortCnt), 0);
        reset = 1'b0;
        clks(5);

        v1 = n_v1;
        frame(32'h18ABCC, 24);
        check_eq("t1_d0", 32'(asoData0), 32'h2AF3);
        check_eq("t1_fw", 32'(frmWord), 32'h18ABCC);
        check_eq("t1_v1_none", n_v1 - v1, 0);

        v0 = n_v0;
        frame(32'h198000, 24);
        check_eq("t2_d1_first", 32'(asoData1), 32'h0000);
        frame(32'h190000, 24);
        check_eq("t2_d1_second", 32'(asoData1), 32'h2000);
        check_eq("t2_v0_none", n_v0 - v0, 0);

        v0 = n_v0;
        v1 = n_v1;
        frame(32'h1F4000, 24);
        check_eq("t3_v0_count", n_v0 - v0, 1);
        check_eq("t3_v1_count", n_v1 - v1, 1);
        check_eq("t3_same_cycle", 32'(t_v0 - t_v1), 0);
        check_eq("t3_d0", 32'(asoData0), 32'h1000);
        check_eq("t3_d1", 32'(asoData1), 32'h3000);

        f = n_f;
        dacSync = 1'b0;
        clks(2);
        send_bits(32'h2AA, 10);
        end_frame();
        check_eq("t4_no_frame", n_f - f, 0);
        check_eq("t4_abort", 32'(abortCnt), 1);
        frame(32'h180004, 24);
        check_eq("t4_d0", 32'(asoData0), 32'h0001);

        v0 = n_v0;
        v1 = n_v1;
        f = n_f;
        frame(32'h380001, 24);
        frame({8'h0, 24'h380001} << 2 | 32'h3, 26);
        check_eq("t5_frames", n_f - f, 2);
        check_eq("t5_fw", 32'(frmWord), 32'h380001);
        check_eq("t5_no_aso", (n_v0 - v0) + (n_v1 - v1), 0);

        f = n_f;
        dacSync = 1'b0;
        clks(2);
        send_bits(32'hABC, 12);
        reset = 1'b1;
        clks(3);
        reset = 1'b0;
        send_bits(32'hDEF, 12);
        end_frame();
        check_eq("t6_no_frame", n_f - f, 0);
        check_eq("t6_abort", 32'(abortCnt), 0);
        frame(32'h181234, 24);
        check_eq("t6_d0", 32'(asoData0), 32'h048D);

        for (int i = 0; i < 150; i++) begin
            a = 14'($urandom_range(0, 16383));
            b = 14'($urandom_range(0, 16383));
            frame({8'h0, 8'h18, a, 2'($urandom)}, 24);
            frame({8'h0, 8'h19, b ^ 14'h2000, 2'($urandom)}, 24);
            check_eq("loop_a", 32'(asoData0), 32'(a));
            check_eq("loop_b", 32'(asoData1), 32'(b));
        end
        check_eq("loop_abort", 32'(abortCnt), 0);

        clks(10);
        check_eq("drain_a", exp_a.size(), 0);
        check_eq("drain_b", exp_b.size(), 0);
        check_eq("drain_f", exp_f.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ad56x3_frame_rx.md
# ad56x3_frame_rx

Serial-frame receiver for the AD56x3 three-wire interface (dacSync / dacSclk / dacDin). It is the slave end of the link driven by the drvAd56x3 transmitter. It deserializes 24-bit frames, decodes command and address, and re-emits channel A/B samples as Avalon-ST sources in the system clock domain. It is used as a synthesizable loopback checker on the FPGA and as a DAC stand-in in system benches.

## Interface
- SIGN_A, "UNSIGNED": "SIGNED" inverts the MSB of the channel A output (offset binary to two's complement).
- SIGN_B, "SIGNED": same as SIGN_A, for channel B.
- DATA_WIDTH, 14: output sample width; legal range 12..16; taken from bits [15:16-DATA_WIDTH] of the data field.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- dacSync  in  1  frame enable, active low.
- dacSclk  in  1  serial clock; data is sampled on its falling edge.
- dacDin  in  1  serial data, MSB first.
- asoValid0  out  1  channel A sample strobe, one clk wide.
- asoData0  out  DATA_WIDTH  channel A sample.
- asoValid1  out  1  channel B sample strobe, one clk wide.
- asoData1  out  DATA_WIDTH  channel B sample.
- frmValid  out  1  strobe for any completed 24-bit frame.
- frmWord  out  24  last completed frame, raw.
- abortCnt  out  8  count of truncated frames, saturating.

## Operation
- Input conditioning: dacSync, dacSclk and dacDin each pass through a 2-FF synchronizer, followed by a third delay flop on sync and sclk for edge detection.
  - Falling sclk = sclk_s2 is 0 while sclk_d is 1.
  - Rising sync = sync_s2 is 1 while sync_d is 0.
- Frame layout: bits [23:22] don't care; [21:19] command; [18:16] address; [15:0] data.
- FSM states:
  - IDLE: waits for sync_s2 = 0. Clears bitCnt and goes to SHIFT.
  - SHIFT: on each falling sclk, shifts din_s2 into a 24-bit shift register and increments bitCnt.
    - When bitCnt reaches 24, latches the word and goes to WAIT_HIGH.
    - If sync rises with bitCnt 1..23: discards the frame, increments abortCnt (saturating at 255) and returns to IDLE.
    - If sync rises with bitCnt 0: returns to IDLE with no count change.
  - WAIT_HIGH: ignores any further falling sclk edges. Returns to IDLE when sync_s2 = 1. Extra bits are not an error.
- On frame completion:
  - frmWord is loaded and frmValid pulses.
  - Command decode:
    - Commands 000, 010 and 011 are writes.
    - Address 000 selects A, 001 selects B, 111 selects both.
    - Any other command or address produces no asoValid.
  - Sample formatting: sample = data[15:16-DATA_WIDTH]. The MSB is XORed with 1 when the channel is "SIGNED".
  - For address 111, asoValid0 and asoValid1 pulse in the same cycle.
- No backpressure. The serial link cannot be stalled, so no ready inputs exist.
- Reset:
  - The FSM goes to WAIT_HIGH, not IDLE. A frame interrupted by reset is never captured, even if sync is still low at release.
  - bitCnt is cleared and abortCnt is not incremented.

## Timing
- Reset values: asoValid0/1 = 0, asoData0/1 = 0, frmValid = 0, frmWord = 0, abortCnt = 0, synchronizer flops = 1 for sync and sclk and 0 for din.
- Latency: dacSclk falls before clk edge N and is detected at edge N+2. frmValid, frmWord, asoValid* and asoData* are registered at edge N+3, valid for 1 cycle.
- asoData* holds its value between strobes.
- Minimum input timing: each sclk phase lasts ≥2 clk, and sync stays high ≥2 clk between frames. The driver with SCLK_DIVIDER=2 and SYNC_DURATION=5 meets this.
- Back-to-back frames: the next frame's sync fall may occur in the same cycle as the previous frame's output strobes.
- Simultaneous sync rise and 24th sclk fall (same detect cycle): the frame counts as complete.

## Test plan
- Frame 0x18ABCC (cmd 011, addr A), SIGN_A unsigned, DATA_WIDTH 14 -> asoValid0 one pulse, asoData0 = 0x2AF3, asoValid1 = 0, frmWord = 0x18ABCC.
- Frames 0x198000 then 0x190000 on SIGN_B signed -> asoData1 = 0x0000, then 0x2000; asoValid0 never asserts.
- Frame 0x1F4000 (addr 111) -> asoValid0 and asoValid1 in the same cycle, asoData0 = 0x1000, asoData1 = 0x3000.
- Sync raised after 10 bits, then full frame 0x180004 -> no strobe for the first frame, abortCnt = 1, then asoData0 = 0x0001.
- Frame 0x380001 (cmd 111) -> frmValid with frmWord = 0x380001; no asoValid. 26 sclk edges in one frame -> exactly one frmValid.
- Reset asserted after 12 bits and released with sync low, remaining 12 bits sent -> no strobes, abortCnt = 0. Next full frame 0x181234 -> asoData0 = 0x048D.
- Loopback with drvAd56x3 (SCLK_DIVIDER 2, SYNC_DURATION 5) for 1000 random sample pairs -> every received pair equals the sent pair, abortCnt = 0.
